// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the multiply/divide controller: widths, MD op codes
// (same values the ID decoder emits) and FSM state encodings.
package muldiv_ctrl_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;
    localparam int MD_OP_W  = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // True for the four ops that start an iterative operation
    function automatic logic is_arith_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-side bundle between the pipeline and the multiply/divide controller.
interface muldiv_ctrl_if
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic               ex_valid;
    logic [MD_OP_W-1:0] ex_md_op;
    logic [XLEN-1:0]    rsv;
    logic [XLEN-1:0]    rtv;
    logic               md_stall;
    logic               busy;
    logic [XLEN-1:0]    hi;
    logic [XLEN-1:0]    lo;
    logic [XLEN-1:0]    mf_value;

    modport master (
        output ex_valid, ex_md_op, rsv, rtv,
        input  md_stall, busy, hi, lo, mf_value
    );

    modport slave (
        input  ex_valid, ex_md_op, rsv, rtv,
        output md_stall, busy, hi, lo, mf_value
    );
endinterface

// File: rtl/muldiv_ctrl_md_iter_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Multiply: acc = {partial, multiplier}; add b on the low bit, shift right.
// Divide:   acc = {remainder, dividend}; shift left, restoring subtract.
module md_iter_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    // Compute both candidate next values and pick by operation kind
    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh[XLEN-1:0] - b;
        if (is_div) begin
            if (rem_sh >= {1'b0, b}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, runs 32 iterations per
// MULT/DIV, applies sign correction, and stalls later MD-class instructions.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  md
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   raw_rs_q, raw_rs_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              md_req;
    logic [2*XLEN-1:0] acc_step;
    logic              rs_neg;
    logic              rt_neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign md_req = md.ex_valid && (md.ex_md_op != MD_NONE);

    md_iter_step #(.XLEN(XLEN)) u_step (
        .acc      (acc_q),
        .b        (b_q),
        .is_div   (is_div_q),
        .acc_next (acc_step)
    );

    // Next-state logic: accept/MT* in IDLE, iterate in CALC, sign-fix and commit in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        raw_rs_d  = raw_rs_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rs_neg    = is_signed_op(md.ex_md_op) && md.rsv[XLEN-1];
        rt_neg    = is_signed_op(md.ex_md_op) && md.rtv[XLEN-1];
        prod      = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (state_q)
            ST_IDLE: begin
                if (md_req && is_arith_op(md.ex_md_op)) begin
                    acc_d     = {{XLEN{1'b0}}, (rs_neg ? -md.rsv : md.rsv)};
                    b_d       = rt_neg ? -md.rtv : md.rtv;
                    raw_rs_d  = md.rsv;
                    is_div_d  = is_div_op(md.ex_md_op);
                    neg_d     = rs_neg ^ rt_neg;
                    rem_neg_d = rs_neg;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end else if (md_req && md.ex_md_op == MD_MTHI) begin
                    hi_d = md.rsv;
                end else if (md_req && md.ex_md_op == MD_MTLO) begin
                    lo_d = md.rsv;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end else if (b_q == '0) begin
                    hi_d = raw_rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            raw_rs_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            raw_rs_q  <= raw_rs_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // HI/LO read mux for MFHI/MFLO, zero otherwise
    always_comb begin
        md.mf_value = '0;
        if (md.ex_valid && md.ex_md_op == MD_MFHI) begin
            md.mf_value = hi_q;
        end else if (md.ex_valid && md.ex_md_op == MD_MFLO) begin
            md.mf_value = lo_q;
        end
    end

    assign md.md_stall = md_req && (state_q != ST_IDLE);
    assign md.busy     = (state_q != ST_IDLE);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_ctrl_if #(.XLEN(32)) bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid = v;
        bus.ex_md_op = op;
        bus.rsv      = a;
        bus.rtv      = b;
        #1;
    endtask

    // Issue one MULT/DIV from idle, follow its 34-edge lifetime, check the result
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(1'b1, op, a, b);
        check({tag, "_accept_stall"}, 64'(bus.md_stall), 64'd0);
        tick();
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        check({tag, "_busy_after_e0"}, 64'(bus.busy), 64'd1);
        repeat (32) tick();
        check({tag, "_busy_after_e32"}, 64'(bus.busy), 64'd1);
        tick();
        check({tag, "_busy_after_e33"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_stall", 64'(bus.md_stall), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_minxmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg7by2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100by7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_by0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_by0", MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MULT 6x7, a non-MD instruction, then MFLO waiting on the result
        drive(1'b1, MD_MULT, 32'd6, 32'd7);
        tick();
        drive(1'b1, MD_NONE, 32'd1, 32'd2);
        check("addu_no_stall", 64'(bus.md_stall), 64'd0);
        check("addu_busy", 64'(bus.busy), 64'd1);
        tick();
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check("mflo_wait_stall", 64'(bus.md_stall), 64'd1);
            tick();
        end
        check("mflo_release_stall", 64'(bus.md_stall), 64'd0);
        check("mflo_value", 64'(bus.mf_value), 64'd42);
        tick();

        // Idle MTHI then MFHI in the next cycle
        drive(1'b1, MD_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_stall", 64'(bus.md_stall), 64'd0);
        tick();
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        drive(1'b1, MD_MFHI, 32'd0, 32'd0);
        check("mfhi_value", 64'(bus.mf_value), 64'h1234);
        check("mfhi_stall", 64'(bus.md_stall), 64'd0);
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        check("mfhi_invalid_value", 64'(bus.mf_value), 64'd0);
        tick();
        drive(1'b1, MD_MTLO, 32'hCAFE_0001, 32'd0);
        tick();
        check("mtlo_lo", 64'(bus.lo), 64'hCAFE_0001);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

        // Reset in the middle of CALC
        drive(1'b1, MD_MULTU, 32'd5, 32'd9);
        tick();
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        repeat (10) tick();
        check("bubble_mf_no_stall", 64'(bus.md_stall), 64'd0);
        check("midcalc_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        run_op("multu_2x3", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
